// File: rtl/user_obi_dma.sv
// user_obi_dma: register-programmed OBI copy engine for the user domain.
// Copies LEN bytes word by word from SRC to DST with one outstanding
// transaction and raises a level interrupt on completion.
// Optional build macro USER_OBI_DMA_FILL_EN adds CTRL.fill and PATTERN:
// a fill transfer skips the reads and writes PATTERN to every word.
// Register map (addr[4:2]): 0 SRC, 1 DST, 2 LEN, 3 CTRL, 4 STATUS, 5 PATTERN.
// Handshake: an access is taken in the cycle req is high (gnt = req);
// rvalid follows exactly one cycle later carrying the request's aid.

package user_obi_dma_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiCfgDefault = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module user_obi_dma #(
  parameter user_obi_dma_pkg::obi_cfg_t SbrObiCfg = user_obi_dma_pkg::ObiCfgDefault,
  parameter user_obi_dma_pkg::obi_cfg_t MgrObiCfg = user_obi_dma_pkg::ObiCfgDefault,
  parameter type sbr_obi_req_t = user_obi_dma_pkg::obi_req_t,
  parameter type sbr_obi_rsp_t = user_obi_dma_pkg::obi_rsp_t,
  parameter type mgr_obi_req_t = user_obi_dma_pkg::obi_req_t,
  parameter type mgr_obi_rsp_t = user_obi_dma_pkg::obi_rsp_t,
  parameter int unsigned LenWidth = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t sbr_obi_req_i,
  output sbr_obi_rsp_t sbr_obi_rsp_o,
  output mgr_obi_req_t mgr_obi_req_o,
  input  mgr_obi_rsp_t mgr_obi_rsp_i,
  output logic         busy_o,
  output logic         irq_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;

  localparam logic [2:0] RegSrc     = 3'd0;
  localparam logic [2:0] RegDst     = 3'd1;
  localparam logic [2:0] RegLen     = 3'd2;
  localparam logic [2:0] RegCtrl    = 3'd3;
  localparam logic [2:0] RegStatus  = 3'd4;
  localparam logic [2:0] RegPattern = 3'd5;

  localparam logic [LenWidth-3:0] WordOne = {{(LenWidth-3){1'b0}}, 1'b1};

  logic [2:0]                     state_q;
  logic [31:0]                    src_q, dst_q, cur_src_q, cur_dst_q;
  logic [LenWidth-3:0]            len_q, words_q;
  logic [MgrObiCfg.DataWidth-1:0] data_q;
  logic                           irq_en_q, done_q, err_q;
  logic                           rvalid_q;
  logic [SbrObiCfg.IdWidth-1:0]   rid_q;
  logic [31:0]                    rdata_q, rdata_d;

  logic        reg_wr, reg_rd, cfg_wr, start, busy;
  logic [2:0]  reg_idx;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata, len_full, len_merged;
  logic        fill_start, cur_fill, fill_rd;
  logic [31:0] pattern_rd;
  logic        unused_ok;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wr_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr_val[8*i +: 8];
    end
    return res;
  endfunction

  assign reg_wr    = sbr_obi_req_i.req & sbr_obi_req_i.a.we;
  assign reg_rd    = sbr_obi_req_i.req & ~sbr_obi_req_i.a.we;
  assign reg_idx   = sbr_obi_req_i.a.addr[4:2];
  assign reg_be    = sbr_obi_req_i.a.be;
  assign reg_wdata = sbr_obi_req_i.a.wdata;
  assign busy      = (state_q != IDLE);
  // Configuration registers are frozen while a transfer runs.
  assign cfg_wr    = reg_wr & ~busy;
  assign start     = reg_wr && (reg_idx == RegCtrl) && reg_be[0] && reg_wdata[0] && !busy;

  assign len_full   = {{(32-LenWidth){1'b0}}, len_q, 2'b00};
  assign len_merged = be_merge(len_full, reg_wdata, reg_be);

  assign busy_o = busy;
  assign irq_o  = done_q & irq_en_q;

`ifdef USER_OBI_DMA_FILL_EN
  logic        fill_q, cur_fill_q;
  logic [31:0] pattern_q;

  // Fill configuration; the mode seen at start is kept for the whole transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q     <= 1'b0;
      cur_fill_q <= 1'b0;
      pattern_q  <= '0;
    end else begin
      if (cfg_wr && reg_idx == RegPattern) pattern_q <= be_merge(pattern_q, reg_wdata, reg_be);
      if (cfg_wr && reg_idx == RegCtrl && reg_be[0]) fill_q <= reg_wdata[2];
      if (start) cur_fill_q <= fill_start;
    end
  end

  // start always comes with a CTRL write of byte 0, so that write decides the mode.
  assign fill_start = reg_wdata[2];
  assign cur_fill   = cur_fill_q;
  assign fill_rd    = fill_q;
  assign pattern_rd = pattern_q;
`else
  assign fill_start = 1'b0;
  assign cur_fill   = 1'b0;
  assign fill_rd    = 1'b0;
  assign pattern_rd = '0;
`endif

  // Register read mux.
  always_comb begin
    rdata_d = '0;
    case (reg_idx)
      RegSrc:     rdata_d = src_q;
      RegDst:     rdata_d = dst_q;
      RegLen:     rdata_d = len_full;
      RegCtrl:    rdata_d = {29'd0, fill_rd, irq_en_q, 1'b0};
      RegStatus:  rdata_d = {29'd0, err_q, done_q, busy};
      RegPattern: rdata_d = pattern_rd;
      default:    rdata_d = '0;
    endcase
  end

  // Programmable registers and the one-cycle subordinate response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (cfg_wr && reg_idx == RegSrc) src_q <= be_merge(src_q, reg_wdata, reg_be);
      if (cfg_wr && reg_idx == RegDst) dst_q <= be_merge(dst_q, reg_wdata, reg_be);
      if (cfg_wr && reg_idx == RegLen) len_q <= len_merged[LenWidth-1:2];
      if (reg_wr && reg_idx == RegCtrl && reg_be[0]) irq_en_q <= reg_wdata[1];
      rvalid_q <= sbr_obi_req_i.req;
      if (sbr_obi_req_i.req) rid_q <= sbr_obi_req_i.a.aid;
      rdata_q  <= reg_rd ? rdata_d : '0;
    end
  end

  // Transfer FSM with the done/err status bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      words_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (reg_wr && reg_idx == RegStatus && reg_be[0]) begin
        if (reg_wdata[1]) done_q <= 1'b0;
        if (reg_wdata[2]) err_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_src_q <= src_q;
            cur_dst_q <= dst_q;
            words_q   <= len_q;
            err_q     <= 1'b0;
            done_q    <= (len_q == '0);
            if (fill_start) data_q <= pattern_rd;
            if (len_q != '0) state_q <= fill_start ? WR_REQ : RD_REQ;
          end
        end
        RD_REQ: if (mgr_obi_rsp_i.gnt) state_q <= RD_WAIT;
        RD_WAIT: begin
          if (mgr_obi_rsp_i.rvalid) begin
            if (mgr_obi_rsp_i.r.err) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              data_q  <= mgr_obi_rsp_i.r.rdata;
              state_q <= WR_REQ;
            end
          end
        end
        WR_REQ: if (mgr_obi_rsp_i.gnt) state_q <= WR_WAIT;
        WR_WAIT: begin
          if (mgr_obi_rsp_i.rvalid) begin
            if (mgr_obi_rsp_i.r.err) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              cur_src_q <= cur_src_q + 32'd4;
              cur_dst_q <= cur_dst_q + 32'd4;
              words_q   <= words_q - WordOne;
              if (words_q == WordOne) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= cur_fill ? WR_REQ : RD_REQ;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Manager request: driven only in the REQ states, word-aligned addresses.
  always_comb begin
    mgr_obi_req_o = '0;
    if (state_q == RD_REQ) begin
      mgr_obi_req_o.req    = 1'b1;
      mgr_obi_req_o.a.addr = cur_src_q & 32'hFFFF_FFFC;
      mgr_obi_req_o.a.be   = 4'hF;
    end else if (state_q == WR_REQ) begin
      mgr_obi_req_o.req     = 1'b1;
      mgr_obi_req_o.a.we    = 1'b1;
      mgr_obi_req_o.a.addr  = cur_dst_q & 32'hFFFF_FFFC;
      mgr_obi_req_o.a.be    = 4'hF;
      mgr_obi_req_o.a.wdata = data_q;
    end
  end

  // Subordinate response: grant is immediate, data and id follow one cycle later.
  always_comb begin
    sbr_obi_rsp_o         = '0;
    sbr_obi_rsp_o.gnt     = sbr_obi_req_i.req;
    sbr_obi_rsp_o.rvalid  = rvalid_q;
    sbr_obi_rsp_o.r.rdata = rdata_q;
    sbr_obi_rsp_o.r.rid   = rid_q;
    sbr_obi_rsp_o.r.err   = 1'b0;
  end

  assign unused_ok = ^{sbr_obi_req_i.a.addr[31:5], sbr_obi_req_i.a.addr[1:0],
                       mgr_obi_rsp_i.r.rid, len_merged[31:LenWidth], len_merged[1:0]};

endmodule

// File: tb/tb_user_obi_dma.sv
// Directed bench for user_obi_dma: register access, copy, zero length,
// read error, busy protection, reset mid-transfer and (with
// USER_OBI_DMA_FILL_EN) pattern fill, against a zero-wait memory model.

module tb_user_obi_dma;
  import user_obi_dma_pkg::*;

  localparam logic [31:0] A_SRC  = 32'h00;
  localparam logic [31:0] A_DST  = 32'h04;
  localparam logic [31:0] A_LEN  = 32'h08;
  localparam logic [31:0] A_CTRL = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;
  localparam logic [31:0] A_PAT  = 32'h14;

  logic     clk = 1'b0;
  logic     rst;
  obi_req_t sbr_req;
  obi_rsp_t sbr_rsp;
  obi_req_t mgr_req;
  obi_rsp_t mgr_rsp;
  logic     busy, irq;

  logic        m_rvalid, m_err;
  logic [31:0] m_rdata;

  logic [31:0] mem [logic [31:0]];
  logic        err_en;
  logic [31:0] err_addr;
  logic        pend_valid, pend_err;
  logic [31:0] pend_data;

  logic [64:0] act_q[$];
  logic [64:0] exp_q[$];
  int          busy_cycles;
  logic        req_seen;

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  user_obi_dma dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sbr_obi_req_i (sbr_req),
    .sbr_obi_rsp_o (sbr_rsp),
    .mgr_obi_req_o (mgr_req),
    .mgr_obi_rsp_i (mgr_rsp),
    .busy_o        (busy),
    .irq_o         (irq)
  );

  assign mgr_rsp = {mgr_req.req, m_rvalid, m_rdata, 4'd0, m_err};

  // Memory model: sample the request mid-cycle, log it, respond next cycle.
  always @(negedge clk) begin
    pend_valid = 1'b0;
    pend_err   = 1'b0;
    pend_data  = 32'h0;
    if (!rst && mgr_req.req) begin
      pend_valid = 1'b1;
      act_q.push_back({mgr_req.a.we, mgr_req.a.addr, mgr_req.a.we ? mgr_req.a.wdata : 32'h0});
      if (mgr_req.a.we) mem[mgr_req.a.addr] = mgr_req.a.wdata;
      else if (err_en && mgr_req.a.addr == err_addr) pend_err = 1'b1;
      else if (mem.exists(mgr_req.a.addr)) pend_data = mem[mgr_req.a.addr];
    end
    if (mgr_req.req) req_seen = 1'b1;
    if (busy) busy_cycles++;
  end

  // Memory model response register.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rvalid <= 1'b0;
      m_rdata  <= 32'h0;
      m_err    <= 1'b0;
    end else begin
      m_rvalid <= pend_valid;
      m_rdata  <= pend_data;
      m_err    <= pend_err;
    end
  end

  function automatic logic [64:0] ent(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  // driver tasks
  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    sbr_req.req     = 1'b1;
    sbr_req.a.addr  = addr;
    sbr_req.a.we    = 1'b1;
    sbr_req.a.be    = be;
    sbr_req.a.wdata = data;
    sbr_req.a.aid   = 4'd0;
    @(posedge clk);
    #1;
    sbr_req = '0;
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    sbr_req.req    = 1'b1;
    sbr_req.a.addr = addr;
    sbr_req.a.we   = 1'b0;
    sbr_req.a.be   = 4'hF;
    sbr_req.a.aid  = 4'd0;
    @(posedge clk);
    #1;
    sbr_req = '0;
    data = sbr_rsp.r.rdata;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1;
    sbr_req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq); end
    total++; if (mgr_req.req !== 1'b0) begin bad++; $display("FAIL reset_mgr_req got %b want 0", mgr_req.req); end
    total++; if (sbr_rsp.rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", sbr_rsp.rvalid); end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got %h want 0", d); end
  endtask

  task automatic test_reg_access;
    logic [31:0] d;
    reg_write(A_SRC, 32'h1000_0000, 4'hF);
    reg_write(A_DST, 32'h1000_0100, 4'hF);
    reg_write(A_LEN, 32'h0000_000C, 4'hF);
    reg_write(A_CTRL, 32'h0000_0002, 4'hF);
    reg_read(A_DST, d);
    total++; if (d !== 32'h1000_0100) begin bad++; $display("FAIL rd_dst got %h want 10000100", d); end
    reg_read(A_LEN, d);
    total++; if (d !== 32'h0000_000C) begin bad++; $display("FAIL rd_len got %h want c", d); end
    reg_read(A_CTRL, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL rd_ctrl got %h want 2", d); end
    // explicit SRC read checking grant, rvalid timing and rid
    @(negedge clk);
    sbr_req.req = 1'b1; sbr_req.a.addr = A_SRC; sbr_req.a.we = 1'b0;
    sbr_req.a.be = 4'hF; sbr_req.a.aid = 4'd5;
    #1;
    total++; if (sbr_rsp.gnt !== 1'b1) begin bad++; $display("FAIL gnt got %b want 1", sbr_rsp.gnt); end
    @(posedge clk); #1;
    sbr_req = '0;
    total++; if (sbr_rsp.rvalid !== 1'b1) begin bad++; $display("FAIL rvalid got %b want 1", sbr_rsp.rvalid); end
    total++; if (sbr_rsp.r.rid !== 4'd5) begin bad++; $display("FAIL rid got %h want 5", sbr_rsp.r.rid); end
    total++; if (sbr_rsp.r.rdata !== 32'h1000_0000) begin bad++; $display("FAIL rd_src got %h want 10000000", sbr_rsp.r.rdata); end
    @(posedge clk); #1;
    total++; if (sbr_rsp.rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_drop got %b want 0", sbr_rsp.rvalid); end
    reg_write(A_LEN, 32'h0000_000F, 4'hF);
    reg_read(A_LEN, d);
    total++; if (d !== 32'h0000_000C) begin bad++; $display("FAIL len_low_bits got %h want c", d); end
    reg_write(A_SRC, 32'h1234_5678, 4'b0101);
    reg_read(A_SRC, d);
    total++; if (d !== 32'h1034_0078) begin bad++; $display("FAIL src_be got %h want 10340078", d); end
    reg_write(A_SRC, 32'h1000_0000, 4'hF);
    reg_write(32'h18, 32'hFFFF_FFFF, 4'hF);
    reg_read(32'h18, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped got %h want 0", d); end
    total++; if (sbr_rsp.r.err !== 1'b0) begin bad++; $display("FAIL unmapped_err got %b want 0", sbr_rsp.r.err); end
`ifndef USER_OBI_DMA_FILL_EN
    reg_write(A_PAT, 32'hDEAD_BEEF, 4'hF);
    reg_read(A_PAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL pattern_absent got %h want 0", d); end
    reg_write(A_CTRL, 32'h0000_0006, 4'hF);
    reg_read(A_CTRL, d);
    total++; if (d !== 32'h0000_0002) begin bad++; $display("FAIL fill_absent got %h want 2", d); end
`endif
  endtask

  task automatic test_copy;
    logic [31:0] d;
    bit ok;
    mem[32'h1000_0000] = 32'hA5A5_0001;
    mem[32'h1000_0004] = 32'hA5A5_0002;
    mem[32'h1000_0008] = 32'hA5A5_0003;
    reg_write(A_LEN, 32'h0000_000C, 4'hF);
    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ent(1'b0, 32'h1000_0000 + 32'(4*i), 32'h0));
      exp_q.push_back(ent(1'b1, 32'h1000_0100 + 32'(4*i), 32'hA5A5_0001 + 32'(i)));
    end
    busy_cycles = 0;
    reg_write(A_CTRL, 32'h0000_0003, 4'hF);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL copy_timeout got %b want 1", ok); end
    total++; if (act_q.size() !== exp_q.size()) begin bad++; $display("FAIL copy_count got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL copy_txn[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
      end
    end
    total++; if (busy_cycles !== 12) begin bad++; $display("FAIL copy_cycles got %0d want 12", busy_cycles); end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL copy_status got %h want 2", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL copy_irq got %b want 1", irq); end
    reg_write(A_STAT, 32'h2, 4'hF);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_len_zero;
    logic [31:0] d;
    reg_write(A_LEN, 32'h0, 4'hF);
    reg_read(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL len0_pre_status got %h want 0", d); end
    req_seen = 1'b0;
    reg_write(A_CTRL, 32'h0000_0003, 4'hF);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL len0_done_next got %b want 1", irq); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy got %b want 0", busy); end
    repeat (5) @(negedge clk);
    total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL len0_no_req got %b want 0", req_seen); end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL len0_status got %h want 2", d); end
    reg_write(A_STAT, 32'h6, 4'hF);
  endtask

  task automatic test_read_err;
    logic [31:0] d;
    bit ok;
    int nw;
    err_en = 1'b1;
    err_addr = 32'h1000_0004;
    reg_write(A_SRC, 32'h1000_0000, 4'hF);
    reg_write(A_DST, 32'h1000_0200, 4'hF);
    reg_write(A_LEN, 32'h0000_000C, 4'hF);
    act_q.delete();
    exp_q.delete();
    exp_q.push_back(ent(1'b0, 32'h1000_0000, 32'h0));
    exp_q.push_back(ent(1'b1, 32'h1000_0200, 32'hA5A5_0001));
    exp_q.push_back(ent(1'b0, 32'h1000_0004, 32'h0));
    reg_write(A_CTRL, 32'h0000_0001, 4'hF);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_timeout got %b want 1", ok); end
    repeat (2) @(negedge clk);
    nw = 0;
    foreach (act_q[i]) if (act_q[i][64]) nw++;
    total++; if (nw !== 1) begin bad++; $display("FAIL err_writes got %0d want 1", nw); end
    total++; if (act_q.size() !== 3) begin bad++; $display("FAIL err_count got %0d want 3", act_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_txn[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
      end
    end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL err_status got %h want 6", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_busy got %b want 0", busy); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL err_irq_masked got %b want 0", irq); end
    err_en = 1'b0;
    reg_write(A_STAT, 32'h6, 4'hF);
    reg_read(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_status got %h want 0", d); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] d;
    bit ok;
    int nw;
    mem[32'h1000_000C] = 32'hA5A5_0004;
    reg_write(A_DST, 32'h1000_0300, 4'hF);
    reg_write(A_LEN, 32'h0000_0010, 4'hF);
    act_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ent(1'b0, 32'h1000_0000 + 32'(4*i), 32'h0));
      exp_q.push_back(ent(1'b1, 32'h1000_0300 + 32'(4*i), 32'hA5A5_0001 + 32'(i)));
    end
    reg_write(A_CTRL, 32'h0000_0001, 4'hF);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bi_busy got %b want 1", busy); end
    reg_write(A_DST, 32'h1000_0400, 4'hF);
    reg_write(A_CTRL, 32'h0000_0001, 4'hF);
    reg_write(A_LEN, 32'h0000_0004, 4'hF);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bi_timeout got %b want 1", ok); end
    repeat (2) @(negedge clk);
    nw = 0;
    foreach (act_q[i]) if (act_q[i][64]) nw++;
    total++; if (nw !== 4) begin bad++; $display("FAIL bi_writes got %0d want 4", nw); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL bi_txn[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
      end
    end
    reg_read(A_DST, d);
    total++; if (d !== 32'h1000_0300) begin bad++; $display("FAIL bi_dst got %h want 10000300", d); end
    reg_read(A_LEN, d);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL bi_len got %h want 10", d); end
    reg_write(A_STAT, 32'h6, 4'hF);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    bit seen;
    reg_write(A_DST, 32'h1000_0500, 4'hF);
    reg_write(A_LEN, 32'h0000_0008, 4'hF);
    reg_write(A_CTRL, 32'h0000_0003, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mgr_req.req && mgr_req.a.we) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rm_wr_req_seen got %b want 1", seen); end
    #2 rst = 1'b1;
    #1;
    total++; if (mgr_req.req !== 1'b0) begin bad++; $display("FAIL rm_mgr_req got %b want 0", mgr_req.req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reg_read(A_SRC, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_src got %h want 0", d); end
    reg_read(A_DST, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_dst got %h want 0", d); end
    reg_read(A_LEN, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_len got %h want 0", d); end
    reg_read(A_CTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_ctrl got %h want 0", d); end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rm_status got %h want 0", d); end
  endtask

`ifdef USER_OBI_DMA_FILL_EN
  task automatic test_fill;
    logic [31:0] d;
    bit ok;
    reg_write(A_PAT, 32'hDEAD_BEEF, 4'hF);
    reg_write(A_SRC, 32'h1000_0000, 4'hF);
    reg_write(A_DST, 32'h1000_0600, 4'hF);
    reg_write(A_LEN, 32'h0000_0008, 4'hF);
    act_q.delete();
    exp_q.delete();
    exp_q.push_back(ent(1'b1, 32'h1000_0600, 32'hDEAD_BEEF));
    exp_q.push_back(ent(1'b1, 32'h1000_0604, 32'hDEAD_BEEF));
    busy_cycles = 0;
    reg_write(A_CTRL, 32'h0000_0005, 4'hF);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL fill_timeout got %b want 1", ok); end
    total++; if (act_q.size() !== 2) begin bad++; $display("FAIL fill_count got %0d want 2", act_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        total++; if (act_q[i] !== exp_q[i]) begin bad++; $display("FAIL fill_txn[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
      end
    end
    total++; if (busy_cycles !== 4) begin bad++; $display("FAIL fill_cycles got %0d want 4", busy_cycles); end
    reg_read(A_STAT, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL fill_status got %h want 2", d); end
    reg_read(A_PAT, d);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fill_pattern got %h want deadbeef", d); end
  endtask
`endif

  initial begin
    err_en = 1'b0;
    err_addr = 32'h0;
    busy_cycles = 0;
    req_seen = 1'b0;
    sbr_req = '0;
    rst = 1'b1;
    test_reset();
    test_reg_access();
    test_copy();
    test_len_zero();
    test_read_err();
    test_busy_ignore();
    test_reset_mid();
`ifdef USER_OBI_DMA_FILL_EN
    test_fill();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
